// File: rtl/regfile_pkg.sv
// regfile_pkg: shared default parameters and sweep state encoding for regfile_nport
package regfile_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 6;
  localparam bit ZERO_REG = 1'b1;
  localparam bit BYPASS = 1'b1;
  typedef enum logic {IDLE, SWEEP} state_t;
endpackage

// File: rtl/regfile_clr_seq.sv
// regfile_clr_seq: soft-clear FSM that zeroes one entry per cycle across the whole file
module regfile_clr_seq #(
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_we
);
  import regfile_pkg::*;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'((1 << ADDR_W) - 1);
  state_t r_state, w_next;
  logic [ADDR_W:0] r_cnt;
  logic w_last;
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= (r_state == SWEEP) ? r_cnt + 1'b1 : '0;
    end
  always_comb begin
    w_last = r_cnt == LAST;
    w_next = (r_state == IDLE) ? (i_clr ? SWEEP : IDLE) : (w_last ? IDLE : SWEEP);
  end
  assign o_busy = r_state == SWEEP;
  assign o_done = o_busy && w_last;
  assign o_we = o_busy;
  assign o_addr = r_cnt[ADDR_W-1:0];
endmodule

// File: rtl/regfile_nport.sv
// regfile_nport: 2-read/2-write byte-enabled register file with bypass, zero register and soft clear
module regfile_nport #(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter bit ZERO_REG = regfile_pkg::ZERO_REG,
  parameter bit BYPASS   = regfile_pkg::BYPASS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   i_ra1,
  input  logic [ADDR_W-1:0]   i_ra2,
  output logic [DATA_W-1:0]   o_rd1,
  output logic [DATA_W-1:0]   o_rd2,
  input  logic [ADDR_W-1:0]   i_wa1,
  input  logic [ADDR_W-1:0]   i_wa2,
  input  logic [DATA_W-1:0]   i_wd1,
  input  logic [DATA_W-1:0]   i_wd2,
  input  logic                i_we1,
  input  logic                i_we2,
  input  logic [DATA_W/8-1:0] i_wbe1,
  input  logic [DATA_W/8-1:0] i_wbe2,
  input  logic                i_clr,
  output logic                o_busy,
  output logic                o_done
);
  import regfile_pkg::*;
  localparam int NB = DATA_W / 8;
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [ADDR_W-1:0] w_sw_addr;
  logic w_sw_we, w_busy, w_wok1, w_wok2;
  regfile_clr_seq #(.ADDR_W(ADDR_W)) u_seq (
    .clk   (clk),
    .rst   (rst),
    .i_clr (i_clr),
    .o_busy(w_busy),
    .o_done(o_done),
    .o_addr(w_sw_addr),
    .o_we  (w_sw_we)
  );
  assign o_busy = w_busy;
  always_comb begin
    w_wok1 = i_we1 && !w_busy && !(ZERO_REG && i_wa1 == '0);
    w_wok2 = i_we2 && !w_busy && !(ZERO_REG && i_wa2 == '0);
  end
  function automatic logic [DATA_W-1:0] rd_val(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = r_mem[a];
    for (int b = 0; b < NB; b++) begin
      if (BYPASS && w_wok1 && i_wa1 == a && i_wbe1[b]) v[b*8+:8] = i_wd1[b*8+:8];
      if (BYPASS && w_wok2 && i_wa2 == a && i_wbe2[b]) v[b*8+:8] = i_wd2[b*8+:8];
    end
    return (w_busy || (ZERO_REG && a == '0)) ? '0 : v;
  endfunction
  always_comb begin
    o_rd1 = rd_val(i_ra1);
    o_rd2 = rd_val(i_ra2);
  end
  always_ff @(posedge clk)
    if (rst) r_mem <= '{default: '0};
    else if (w_sw_we) r_mem[w_sw_addr] <= '0;
    else
      for (int b = 0; b < NB; b++) begin
        if (w_wok1 && i_wbe1[b]) r_mem[i_wa1][b*8+:8] <= i_wd1[b*8+:8];
        if (w_wok2 && i_wbe2[b]) r_mem[i_wa2][b*8+:8] <= i_wd2[b*8+:8];
      end
endmodule

// File: tb/tb_regfile_nport.sv
// tb_regfile_nport: vector table plus sweep/reset sequences for regfile_nport (bypass and read-first builds)
module tb_regfile_nport;
  logic clk = 1'b0;
  logic rst, clr, we1, we2;
  logic [5:0] ra1, ra2, wa1, wa2;
  logic [31:0] wd1, wd2, rd1, rd2, nrd1, nrd2;
  logic [3:0] wbe1, wbe2;
  logic busy, done, nbusy, ndone;
  int errors = 0, checks = 0;
  int n, dones, done_at;
  always #5 clk = ~clk;
  regfile_nport dut (
    .clk(clk), .rst(rst), .i_ra1(ra1), .i_ra2(ra2), .o_rd1(rd1), .o_rd2(rd2),
    .i_wa1(wa1), .i_wa2(wa2), .i_wd1(wd1), .i_wd2(wd2), .i_we1(we1), .i_we2(we2),
    .i_wbe1(wbe1), .i_wbe2(wbe2), .i_clr(clr), .o_busy(busy), .o_done(done)
  );
  regfile_nport #(.BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .i_ra1(ra1), .i_ra2(ra2), .o_rd1(nrd1), .o_rd2(nrd2),
    .i_wa1(wa1), .i_wa2(wa2), .i_wd1(wd1), .i_wd2(wd2), .i_we1(we1), .i_we2(we2),
    .i_wbe1(wbe1), .i_wbe2(wbe2), .i_clr(clr), .o_busy(nbusy), .o_done(ndone)
  );
  typedef struct {
    logic        we1;
    logic [5:0]  wa1;
    logic [31:0] wd1;
    logic [3:0]  wbe1;
    logic        we2;
    logic [5:0]  wa2;
    logic [31:0] wd2;
    logic [3:0]  wbe2;
    logic [5:0]  ra1;
    logic [5:0]  ra2;
    logic [31:0] e1, e2, n1, n2;
  } vec_t;
  typedef struct {
    string       nm;
    logic [31:0] exp;
  } sb_t;
  vec_t tbl[8];
  sb_t sb[$];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic quiet;
    we1 = 1'b0; we2 = 1'b0; clr = 1'b0; wbe1 = 4'h0; wbe2 = 4'h0;
    wa1 = 6'd0; wa2 = 6'd0; wd1 = 32'h0; wd2 = 32'h0;
  endtask
  initial begin
    logic [31:0] act[4];
    sb_t e;
    tbl[0] = '{1'b1, 6'd5, 32'hDEADBEEF, 4'hF, 1'b0, 6'd0, 32'h0, 4'h0, 6'd5, 6'd0,
               32'hDEADBEEF, 32'h0, 32'h0, 32'h0};
    tbl[1] = '{1'b1, 6'd9, 32'h11111111, 4'hF, 1'b1, 6'd9, 32'h22222222, 4'h3, 6'd5, 6'd9,
               32'hDEADBEEF, 32'h11112222, 32'hDEADBEEF, 32'h0};
    tbl[2] = '{1'b1, 6'd7, 32'hA5A5A5A5, 4'hF, 1'b0, 6'd0, 32'h0, 4'h0, 6'd9, 6'd7,
               32'h11112222, 32'hA5A5A5A5, 32'h11112222, 32'h0};
    tbl[3] = '{1'b1, 6'd0, 32'hFFFFFFFF, 4'hF, 1'b0, 6'd0, 32'h0, 4'h0, 6'd0, 6'd7,
               32'h0, 32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5};
    tbl[4] = '{1'b0, 6'd0, 32'h0, 4'h0, 1'b1, 6'd5, 32'h000000AA, 4'h1, 6'd0, 6'd5,
               32'h0, 32'hDEADBEAA, 32'h0, 32'hDEADBEEF};
    tbl[5] = '{1'b1, 6'd63, 32'h12345678, 4'hA, 1'b1, 6'd63, 32'hAABBCCDD, 4'h6, 6'd5, 6'd63,
               32'hDEADBEAA, 32'h12BBCC00, 32'hDEADBEAA, 32'h0};
    tbl[6] = '{1'b0, 6'd7, 32'h0, 4'hF, 1'b0, 6'd0, 32'h0, 4'h0, 6'd63, 6'd7,
               32'h12BBCC00, 32'hA5A5A5A5, 32'h12BBCC00, 32'hA5A5A5A5};
    tbl[7] = '{1'b0, 6'd0, 32'h0, 4'h0, 1'b0, 6'd0, 32'h0, 4'h0, 6'd7, 6'd0,
               32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5, 32'h0};
    quiet();
    rst = 1'b1; ra1 = 6'd0; ra2 = 6'd0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      ra1 = 6'(i); ra2 = 6'(63 - i);
      #1;
      chk("rst_rd1", rd1, 32'h0);
      chk("rst_nb_rd2", nrd2, 32'h0);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      we1 = tbl[i].we1; wa1 = tbl[i].wa1; wd1 = tbl[i].wd1; wbe1 = tbl[i].wbe1;
      we2 = tbl[i].we2; wa2 = tbl[i].wa2; wd2 = tbl[i].wd2; wbe2 = tbl[i].wbe2;
      ra1 = tbl[i].ra1; ra2 = tbl[i].ra2;
      sb.push_back('{$sformatf("vec%0d_rd1", i), tbl[i].e1});
      sb.push_back('{$sformatf("vec%0d_rd2", i), tbl[i].e2});
      sb.push_back('{$sformatf("vec%0d_nb_rd1", i), tbl[i].n1});
      sb.push_back('{$sformatf("vec%0d_nb_rd2", i), tbl[i].n2});
      #1;
      act = '{rd1, rd2, nrd1, nrd2};
      for (int k = 0; k < 4; k++) begin
        if (sb.size() == 0) chk("sb_empty", 32'd0, 32'd1);
        else begin
          e = sb.pop_front();
          chk(e.nm, act[k], e.exp);
        end
      end
      tick();
    end
    quiet();
    for (int i = 1; i < 64; i++) begin
      we1 = 1'b1; wa1 = 6'(i); wd1 = 32'h5A000000 | 32'(i); wbe1 = 4'hF;
      tick();
    end
    quiet();
    ra1 = 6'd3;
    #1;
    chk("pre_clr_rd", rd1, 32'h5A000003);
    clr = 1'b1; we1 = 1'b1; wa1 = 6'd3; wd1 = 32'hCAFE0003; wbe1 = 4'hF;
    #1;
    chk("clr_we_bypass", rd1, 32'hCAFE0003);
    chk("clr_idle_busy", 32'(busy), 32'd0);
    tick();
    clr = 1'b0; we1 = 1'b1; wa1 = 6'd1; wd1 = 32'hFFFFFFFF;
    we2 = 1'b1; wa2 = 6'd2; wd2 = 32'hFFFFFFFF; wbe2 = 4'hF; ra2 = 6'd63;
    n = 0; dones = 0; done_at = 0;
    for (int c = 0; c < 200; c++) begin
      clr = (c == 30);
      ra1 = 6'(c);
      #1;
      if (!busy) break;
      n++;
      if (done) begin
        dones++;
        done_at = n;
      end
      chk("sweep_rd1", rd1, 32'h0);
      tick();
    end
    chk("sweep_busy_cycles", 32'(n), 32'd64);
    chk("sweep_done_cycle", 32'(done_at), 32'd64);
    chk("sweep_done_pulses", 32'(dones), 32'd1);
    quiet();
    for (int i = 0; i < 64; i++) begin
      ra1 = 6'(i); ra2 = 6'(i);
      #1;
      chk("post_sweep_rd1", rd1, 32'h0);
      chk("post_sweep_nb_rd2", nrd2, 32'h0);
      tick();
    end
    for (int i = 40; i <= 50; i++) begin
      we1 = 1'b1; wa1 = 6'(i); wd1 = 32'h77000000 | 32'(i); wbe1 = 4'hF;
      tick();
    end
    quiet();
    ra1 = 6'd45;
    #1;
    chk("pre_rst_rd", rd1, 32'h7700002D);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n = 0; dones = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (busy) n++;
      if (done) dones++;
      if (c == 19) rst = 1'b1;
      tick();
    end
    rst = 1'b0;
    #1;
    chk("abort_busy_before", 32'(n), 32'd20);
    chk("abort_busy_after", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_done_pulses", 32'(dones), 32'd0);
    for (int i = 38; i <= 52; i++) begin
      ra1 = 6'(i); ra2 = 6'(i);
      #1;
      chk("abort_rd1", rd1, 32'h0);
      chk("abort_nb_rd2", nrd2, 32'h0);
      chk("abort_idle", 32'(busy), 32'd0);
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_nport.md
REGFILE_NPORT -- requirements
Module: regfile_nport

Interface
REQ-001 Parameter DATA_W, default 32: register width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 6: address width; depth SHALL be 2**ADDR_W entries.
REQ-003 Parameter ZERO_REG, default 1: when 1, entry 0 SHALL read as zero and ignore writes.
REQ-004 Parameter BYPASS, default 1: when 1, reads SHALL forward same-cycle write data (write-first); when 0, reads SHALL return stored contents (read-first).
REQ-005 Clock and reset: one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  clock; all state updates on the rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 RA1, RA2  in  ADDR_W  read addresses.
REQ-009 RD1, RD2  out  DATA_W  read data, combinational from RAx.
REQ-010 WA1, WA2  in  ADDR_W  write addresses.
REQ-011 WD1, WD2  in  DATA_W  write data.
REQ-012 WE1, WE2  in  1  write enables.
REQ-013 WBE1, WBE2  in  DATA_W/8  byte enables; bit k gates byte k.
REQ-014 CLR  in  1  soft-clear request; starts the sequential sweep.
REQ-015 BUSY  out  1  high while the sweep is in progress.
REQ-016 DONE  out  1  one-cycle pulse on the final sweep cycle.

Function
REQ-017 Write: on the rising edge with WEn=1 and not BUSY, bytes of entry WAn whose WBEn bit is 1 SHALL take the matching WDn bytes; all other bytes SHALL hold.
REQ-018 Same-address collision: port 2 SHALL win per byte where both WBE bits are set; bytes enabled on only one port SHALL take that port's data.
REQ-019 Read latency: zero cycles (combinational), as for the current register file.
REQ-020 Bypass, BYPASS=1: per byte, RDn SHALL show the value that entry will hold after the edge, applying REQ-017/018 priority.
REQ-021 ZERO_REG=1: RDn SHALL be 0 for RAn=0 regardless of bypass, and writes to 0 SHALL be discarded.
REQ-022 FSM states: IDLE and SWEEP.
REQ-023 In IDLE, CLR=1 SHALL move the FSM to SWEEP with sweep counter 0 on the next edge.
REQ-024 In SWEEP, each cycle SHALL zero entry[counter] and then increment the counter.
REQ-025 When counter = 2**ADDR_W-1, that cycle SHALL assert DONE, and the FSM SHALL return to IDLE on the next edge.
REQ-026 Sweep duration: 2**ADDR_W cycles with BUSY=1.
REQ-027 While BUSY=1: WE1 and WE2 SHALL be ignored, RD1/RD2 SHALL read 0, and CLR SHALL be ignored (no restart).
REQ-028 CLR and WE asserted together in IDLE: the write SHALL complete at that edge; the sweep then clears it.
REQ-029 The sweep counter SHALL be ADDR_W+1 bits wide and SHALL NOT wrap before DONE.

Reset
REQ-030 rst=1 at an edge SHALL zero all entries in that single cycle, force IDLE, clear the counter, and drive BUSY=0 and DONE=0.
REQ-031 rst SHALL take priority over CLR, WE and an in-progress sweep; reset mid-sweep SHALL abort the sweep with no DONE pulse.
REQ-032 After reset, RD1 and RD2 SHALL read 0 for every address.

Structure
REQ-033 Package regfile_pkg SHALL hold the default constants DATA_W, ADDR_W, ZERO_REG and BYPASS, plus the FSM state enum {IDLE, SWEEP}.
REQ-034 The sweep FSM and counter SHALL be a sub-module regfile_clr_seq (ports: clk, rst, CLR, BUSY, DONE, sweep address, sweep write strobe).
REQ-035 Storage, byte merging, port priority and bypass muxing SHALL stay in regfile_nport.

Verification
REQ-036 After rst, write WA1=5, WD1=0xDEADBEEF, WBE1=4'hF; next cycle RA1=5 -> RD1=0xDEADBEEF.
REQ-037 WA1=WA2=9, WD1=0x11111111, WBE1=4'hF, WD2=0x22222222, WBE2=4'h3 -> entry 9 = 0x11112222.
REQ-038 BYPASS=1: RA1=WA1=7, WD1=0xA5A5A5A5, WE1=1 -> RD1=0xA5A5A5A5 in the same cycle. BYPASS=0: RD1 shows the old value in that cycle.
REQ-039 ZERO_REG=1: WA1=0, WD1=0xFFFFFFFF, WE1=1, then RA1=0 -> RD1=0.
REQ-040 Fill entries 1..63 with nonzero data, then pulse CLR -> BUSY=1 for exactly 64 cycles, a DONE pulse on cycle 64, WE ignored throughout, and all entries read 0 afterwards.
REQ-041 Assert rst at sweep cycle 20 -> BUSY=0 next cycle, no DONE pulse, all entries read 0.
